// File: rtl/rng_pkg.sv
// Shared definitions for the RNG scheduler: Q8.24 word type, fallback seed,
// and the scheduler FSM encoding.
package rng_pkg;
   localparam int Q_W = 32;
   typedef logic [Q_W-1:0] q8_24_t;

   // Nonzero fallback seed; an all-zero LFSR state would never leave zero.
   localparam q8_24_t SEED_DEF = 32'h1ACE_B00C;

   localparam logic [1:0] ST_SEED = 2'd0;
   localparam logic [1:0] ST_WARM = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
endpackage

// File: rtl/rng_lfsr_32.sv
// 32-bit Galois LFSR uniform generator; the state word is the Q8.24 output.
// Synchronous reset loads the seed; one step per cycle while enabled.
module rng_lfsr_32
   import rng_pkg::*;
(
   input  logic   clk,
   input  logic   i_rst,
   input  logic   i_en,
   input  q8_24_t i_seed,
   output q8_24_t o_q
);
   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
   localparam q8_24_t TAPS = 32'h8020_0003;

   q8_24_t r_state;

   // Seed load has priority over stepping.
   always_ff @(posedge clk) begin
      if (i_rst)
         r_state <= i_seed;
      else if (i_en)
         r_state <= {1'b0, r_state[Q_W-1:1]} ^ (r_state[0] ? TAPS : '0);
   end

   assign o_q = r_state;
endmodule

// File: rtl/rr_arb_onehot.sv
// Rotating-priority arbiter: first set request at or above i_ptr, wrapping.
module rr_arb_onehot #(
   parameter  int N_REQ = 4,
   localparam int PW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [PW-1:0]    i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic             o_any
);
   logic          w_found;
   logic [PW-1:0] w_idx;

   // Walk the requests starting at the pointer; the first hit wins.
   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = PW'((int'(i_ptr) + i) % N_REQ);
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
      o_any = |i_req;
   end
endmodule

// File: rtl/rng_sched_q8_24.sv
// Shares one LFSR core among N_REQ path engines with round-robin grants.
// Sequences seed load, warm-up discard, then service; every grant gets a
// fresh core state because the core steps in each decision cycle.
module rng_sched_q8_24 #(
   parameter  int          N_REQ    = 4,
   parameter  logic [31:0] SEED_DEF = rng_pkg::SEED_DEF,
   parameter  int          WARMUP   = 16,
   localparam int          IW       = $clog2(N_REQ),
   localparam int          WW       = $clog2(WARMUP + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 seed_load,
   input  logic [31:0]          seed,
   input  logic [N_REQ-1:0]     req,
   output logic [N_REQ-1:0]     gnt,
   output logic                 rand_valid,
   output rng_pkg::q8_24_t      rand_data,
   output logic [IW-1:0]        rand_id,
   output logic                 ready,
   output logic [31:0]          draw_cnt
);
   import rng_pkg::*;

   logic [1:0]       r_state;
   logic [WW-1:0]    r_warm;
   logic [IW-1:0]    r_ptr;
   q8_24_t           r_seed;
   logic [31:0]      r_cnt;
   logic [N_REQ-1:0] r_gnt;
   logic             r_vld;
   q8_24_t           r_data;
   logic [IW-1:0]    r_id;

   logic             w_core_rst;
   logic             w_core_en;
   q8_24_t           w_core_q;
   logic [N_REQ-1:0] w_win;
   logic             w_any;
   logic [IW-1:0]    w_wid;
   logic             w_take;

   rr_arb_onehot #(.N_REQ(N_REQ)) u_arb (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_win),
      .o_any (w_any)
   );

   rng_lfsr_32 u_core (
      .clk    (clk),
      .i_rst  (w_core_rst),
      .i_en   (w_core_en),
      .i_seed (r_seed),
      .o_q    (w_core_q)
   );

   // A reseed request pre-empts any grant decision in the same cycle.
   assign w_take     = (r_state == ST_RUN) && w_any && !seed_load;
   assign w_core_rst = (r_state == ST_SEED);
   assign w_core_en  = !seed_load && ((r_state == ST_WARM) || w_take);

   // One-hot winner to index.
   always_comb begin
      w_wid = '0;
      for (int i = 0; i < N_REQ; i++)
         if (w_win[i]) w_wid = IW'(i);
   end

   // Seeding FSM, round-robin pointer and saturating draw counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_SEED;
         r_warm  <= '0;
         r_ptr   <= '0;
         r_seed  <= SEED_DEF;
         r_cnt   <= '0;
      end else if (seed_load) begin
         r_seed  <= (seed == 32'd0) ? SEED_DEF : seed;
         r_state <= ST_SEED;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_SEED: begin
               r_state <= ST_WARM;
               r_warm  <= WW'(WARMUP - 1);
            end
            ST_WARM: begin
               if (r_warm == '0) r_state <= ST_RUN;
               else              r_warm  <= r_warm - WW'(1);
            end
            ST_RUN: begin
               if (w_take) begin
                  r_ptr <= (w_wid == IW'(N_REQ - 1)) ? '0 : w_wid + IW'(1);
                  if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
               end
            end
            default: r_state <= ST_SEED;
         endcase
      end
   end

   // Registered grant pulse; draw data holds between grants.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gnt  <= '0;
         r_vld  <= 1'b0;
         r_data <= '0;
         r_id   <= '0;
      end else begin
         r_gnt <= w_take ? w_win : '0;
         r_vld <= w_take;
         if (w_take) begin
            r_data <= w_core_q;
            r_id   <= w_wid;
         end
      end
   end

   assign gnt        = r_gnt;
   assign rand_valid = r_vld;
   assign rand_data  = r_data;
   assign rand_id    = r_id;
   assign ready      = (r_state == ST_RUN);
   assign draw_cnt   = r_cnt;
endmodule
